axis_packet_merger: RTL



---
 rtl/axis_packet_merger_if.sv | 30 +++
 rtl/axis_packet_merger.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_merger_if.sv
// AXI-Stream bundle shared by the packet merger input and output ports.
// Master drives payload and valid, slave drives ready.
interface axis_packet_merger_if #(
  parameter int DATA_WIDTH = 16,
  parameter int KEEP_WIDTH = 2,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;

  modport master (
    output tdata, tkeep, tvalid, tlast,
    output tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast,
    input  tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axis_packet_merger.sv
// Merges packet_count input packets into one output packet,
// regenerating tlast and optionally checking input packet length.
module axis_packet_merger #(
  parameter int DATA_WIDTH        = 16,
  parameter int KEEP_ENABLE       = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH        = (KEEP_ENABLE != 0) ? ((DATA_WIDTH + 7) / 8) : 1,
  parameter int ID_ENABLE         = 0,
  parameter int ID_WIDTH          = (ID_ENABLE != 0) ? 8 : 1,
  parameter int DEST_ENABLE       = 0,
  parameter int DEST_WIDTH        = (DEST_ENABLE != 0) ? 8 : 1,
  parameter int USER_ENABLE       = 0,
  parameter int USER_WIDTH        = (USER_ENABLE != 0) ? 8 : 1,
  parameter int PCKT_WIDTH        = 32,
  parameter int ALLOW_LOCKS       = 1,
  parameter int CHECK_PACKET_SIZE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  operation_start,
  input  logic [PCKT_WIDTH-1:0] packet_size,
  input  logic [PCKT_WIDTH-1:0] packet_count,
  input  logic                  lock,
  input  logic                  external_error,
  output logic                  operation_busy,
  output logic                  operation_complete,
  output logic                  operation_error,
  axis_packet_merger_if.slave   s_axis,
  axis_packet_merger_if.master  m_axis
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_ERROR
  } state_t;

  localparam logic [PCKT_WIDTH-1:0] ONE = PCKT_WIDTH'(1);

  state_t state_q, state_d;

  logic [PCKT_WIDTH-1:0] size_q, size_d;
  logic [PCKT_WIDTH-1:0] count_q, count_d;
  logic [PCKT_WIDTH-1:0] beat_q, beat_d;
  logic [PCKT_WIDTH-1:0] pkt_q, pkt_d;

  logic last_taken_q, last_taken_d;
  logic complete_q, complete_d;
  logic valid_q, valid_d;
  logic tlast_q, tlast_d;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [KEEP_WIDTH-1:0] keep_q, keep_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  logic [USER_WIDTH-1:0] user_q, user_d;

  logic                  lock_eff;
  logic                  in_ready;
  logic                  in_fire;
  logic                  out_fire;
  logic                  final_in;
  logic                  size_bad;
  logic [PCKT_WIDTH-1:0] beat_inc;

  assign lock_eff = (ALLOW_LOCKS != 0) && lock;
  assign in_ready = (state_q == S_RUN) && !lock_eff
                 && !last_taken_q
                 && (!valid_q || m_axis.tready);
  assign in_fire  = in_ready && s_axis.tvalid;
  assign out_fire = valid_q && m_axis.tready;
  assign beat_inc = beat_q + ONE;
  assign final_in = s_axis.tlast && (pkt_q == count_q - ONE);

  // Length is wrong if tlast comes early or is missing at the limit.
  assign size_bad = (CHECK_PACKET_SIZE != 0)
                 && (s_axis.tlast ? (beat_inc != size_q)
                                  : (beat_inc == size_q));

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    count_d      = count_q;
    beat_d       = beat_q;
    pkt_d        = pkt_q;
    last_taken_d = last_taken_q;
    complete_d   = 1'b0;
    valid_d      = valid_q;
    tlast_d      = tlast_q;
    data_d       = data_q;
    keep_d       = keep_q;
    id_d         = id_q;
    dest_d       = dest_q;
    user_d       = user_q;

    unique case (state_q)
      S_IDLE, S_ERROR: begin
        if (operation_start) begin
          size_d       = packet_size;
          count_d      = packet_count;
          beat_d       = '0;
          pkt_d        = '0;
          last_taken_d = 1'b0;
          valid_d      = 1'b0;
          tlast_d      = 1'b0;
          if (packet_size == '0 || packet_count == '0)
            state_d = S_ERROR;
          else
            state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (external_error || (in_fire && size_bad)) begin
          state_d = S_ERROR;
          valid_d = 1'b0;
          tlast_d = 1'b0;
        end else begin
          if (out_fire) begin
            valid_d = 1'b0;
            if (tlast_q) begin
              complete_d   = 1'b1;
              state_d      = S_IDLE;
              last_taken_d = 1'b0;
              tlast_d      = 1'b0;
            end
          end
          if (in_fire) begin
            valid_d = 1'b1;
            tlast_d = final_in;
            data_d  = s_axis.tdata;
            keep_d  = s_axis.tkeep;
            id_d    = s_axis.tid;
            dest_d  = s_axis.tdest;
            user_d  = s_axis.tuser;
            beat_d  = s_axis.tlast ? '0 : beat_inc;
            pkt_d   = s_axis.tlast ? pkt_q + ONE : pkt_q;
            if (final_in)
              last_taken_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      size_q       <= '0;
      count_q      <= '0;
      beat_q       <= '0;
      pkt_q        <= '0;
      last_taken_q <= 1'b0;
      complete_q   <= 1'b0;
      valid_q      <= 1'b0;
      tlast_q      <= 1'b0;
      data_q       <= '0;
      keep_q       <= '0;
      id_q         <= '0;
      dest_q       <= '0;
      user_q       <= '0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      count_q      <= count_d;
      beat_q       <= beat_d;
      pkt_q        <= pkt_d;
      last_taken_q <= last_taken_d;
      complete_q   <= complete_d;
      valid_q      <= valid_d;
      tlast_q      <= tlast_d;
      data_q       <= data_d;
      keep_q       <= keep_d;
      id_q         <= id_d;
      dest_q       <= dest_d;
      user_q       <= user_d;
    end
  end

  assign s_axis.tready      = in_ready;
  assign m_axis.tvalid      = valid_q;
  assign m_axis.tlast       = tlast_q;
  assign m_axis.tdata       = data_q;
  assign m_axis.tkeep       = (KEEP_ENABLE != 0) ? keep_q : '0;
  assign m_axis.tid         = (ID_ENABLE != 0) ? id_q : '0;
  assign m_axis.tdest       = (DEST_ENABLE != 0) ? dest_q : '0;
  assign m_axis.tuser       = (USER_ENABLE != 0) ? user_q : '0;
  assign operation_busy     = (state_q == S_RUN);
  assign operation_error    = (state_q == S_ERROR);
  assign operation_complete = complete_q;

endmodule
